puntaje_acumulador: RTL

//  Score stage feeding the debug probe and 7-seg display: counts hits (puntos) and bonus points (puntos_bono).

---
 rtl/puntaje_pkg.sv | 27 ++
 rtl/bin_a_bcd.sv | 63 ++++++
 rtl/puntaje_acumulador.sv | 96 +++++++++
 3 files changed

// File: rtl/puntaje_pkg.sv
// Shared encodings for the score stage: game FSM states, converter states, widths and
// the double-dabble digit adjust helper.
package puntaje_pkg;

    localparam int unsigned ANCHO_BIN  = 9;
    localparam int unsigned N_DIGITOS  = 3;
    localparam int unsigned ANCHO_BCD  = 4 * N_DIGITOS;
    localparam int unsigned ANCHO_DESP = ANCHO_BCD + ANCHO_BIN;

    localparam logic [2:0] ST_REPOSO = 3'd0;
    localparam logic [2:0] ST_JUEGO  = 3'd1;
    localparam logic [2:0] ST_BONO   = 3'd2;
    localparam logic [2:0] ST_FIN    = 3'd3;

    typedef enum logic [1:0] {C_REPOSO, C_CARGA, C_DESPL, C_FIN} conv_estado_e;

    // Add 3 to every BCD digit that is 5 or more, ahead of the next left shift.
    function automatic logic [ANCHO_BCD-1:0] ajustar_bcd(input logic [ANCHO_BCD-1:0] d);
        logic [ANCHO_BCD-1:0] r;
        r = d;
        for (int i = 0; i < N_DIGITOS; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin_a_bcd.sv
// Sequential double-dabble converter: inicio starts a conversion of bin; bcd_* update
// only on completion, together with a one-cycle valido pulse.
module bin_a_bcd
    import puntaje_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inicio,
    input  logic [ANCHO_BIN-1:0] bin,
    output logic [3:0]           bcd_c,
    output logic [3:0]           bcd_d,
    output logic [3:0]           bcd_u,
    output logic                 ocupado,
    output logic                 valido
);

    conv_estado_e          estado_q;
    logic [ANCHO_DESP-1:0] desp_q;
    logic [3:0]            cuenta_q;
    logic [ANCHO_BCD-1:0]  ajustado;

    always_comb ajustado = ajustar_bcd(desp_q[ANCHO_DESP-1 -: ANCHO_BCD]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q <= C_REPOSO;
            desp_q   <= '0;
            cuenta_q <= '0;
            bcd_c    <= '0;
            bcd_d    <= '0;
            bcd_u    <= '0;
            ocupado  <= 1'b0;
            valido   <= 1'b0;
        end else begin
            valido <= 1'b0;
            unique case (estado_q)
                C_REPOSO: begin
                    if (inicio) begin
                        estado_q <= C_CARGA;
                        ocupado  <= 1'b1;
                    end
                end
                C_CARGA: begin
                    desp_q   <= {{ANCHO_BCD{1'b0}}, bin};
                    cuenta_q <= '0;
                    estado_q <= C_DESPL;
                end
                C_DESPL: begin
                    desp_q   <= {ajustado, desp_q[ANCHO_BIN-1:0]} << 1;
                    cuenta_q <= cuenta_q + 4'd1;
                    if (cuenta_q == 4'(ANCHO_BIN - 1)) estado_q <= C_FIN;
                end
                C_FIN: begin
                    {bcd_c, bcd_d, bcd_u} <= desp_q[ANCHO_DESP-1 -: ANCHO_BCD];
                    valido   <= 1'b1;
                    ocupado  <= 1'b0;
                    estado_q <= C_REPOSO;
                end
            endcase
        end
    end

endmodule

// File: rtl/puntaje_acumulador.sv
// Hit/bonus score accumulators with registered total and BCD conversion for the display.
// Define PUNTAJE_RECORD_EN to add the high-score output record.
module puntaje_acumulador
    import puntaje_pkg::*;
#(
    parameter int unsigned PASO_ACIERTO = 1,
    parameter int unsigned PASO_BONO    = 5,
    parameter int unsigned MAX_PARCIAL  = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic [2:0]           presente,
    input  logic                 acierto,
    input  logic                 bono,
    output logic [7:0]           puntos,
    output logic [7:0]           puntos_bono,
    output logic [ANCHO_BIN-1:0] puntos_bin,
    output logic [3:0]           bcd_c,
    output logic [3:0]           bcd_d,
    output logic [3:0]           bcd_u,
    output logic                 bcd_ocupado,
    output logic                 bcd_valido
`ifdef PUNTAJE_RECORD_EN
    ,
    output logic [ANCHO_BIN-1:0] record
`endif
);

    localparam logic [ANCHO_BIN-1:0] MAX9 = ANCHO_BIN'(MAX_PARCIAL);

    logic [ANCHO_BIN-1:0] suma_acierto, suma_bono, suma_bin;
    logic [7:0]           puntos_sig, bono_sig;
    logic                 sucio_q;

    always_comb begin
        suma_acierto = {1'b0, puntos} + ANCHO_BIN'(PASO_ACIERTO);
        suma_bono    = {1'b0, puntos_bono} + ANCHO_BIN'(PASO_BONO);
        suma_bin     = {1'b0, puntos} + {1'b0, puntos_bono};
        puntos_sig   = puntos;
        bono_sig     = puntos_bono;
        if (clr) begin
            puntos_sig = '0;
            bono_sig   = '0;
        end else begin
            // Gating by state also freezes both counters in ST_FIN.
            if (acierto && presente == ST_JUEGO)
                puntos_sig = (suma_acierto > MAX9) ? MAX9[7:0] : suma_acierto[7:0];
            if (bono && presente == ST_BONO)
                bono_sig = (suma_bono > MAX9) ? MAX9[7:0] : suma_bono[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            puntos      <= '0;
            puntos_bono <= '0;
            puntos_bin  <= '0;
            sucio_q     <= 1'b0;
        end else begin
            puntos      <= puntos_sig;
            puntos_bono <= bono_sig;
            puntos_bin  <= suma_bin;
            // A new request wins over the converter accepting the previous one.
            sucio_q     <= clr | (suma_bin != puntos_bin) | (sucio_q & bcd_ocupado);
        end
    end

    bin_a_bcd u_bin_a_bcd (
        .clk     (clk),
        .rst     (rst),
        .inicio  (sucio_q),
        .bin     (puntos_bin),
        .bcd_c   (bcd_c),
        .bcd_d   (bcd_d),
        .bcd_u   (bcd_u),
        .ocupado (bcd_ocupado),
        .valido  (bcd_valido)
    );

`ifdef PUNTAJE_RECORD_EN
    logic [2:0] presente_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presente_q <= ST_REPOSO;
            record     <= '0;
        end else begin
            presente_q <= presente;
            if (presente == ST_FIN && presente_q != ST_FIN && puntos_bin > record)
                record <= puntos_bin;
        end
    end
`endif

endmodule
